// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scanner: pending/shadow word buffering, DRIVE/BLANK digit scan.
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero digit.
module seg_scan_driver #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50_000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DIGITS-1:0]     cs_n,
  output logic [7:0]            dx,
  output logic                  dbg_state
);

  localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit HAS_BLANK = (BLANK_CYC > 0);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {ST_DRIVE = 1'b0, ST_BLANK = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d, disp_q, disp_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                  full_q, full_d;
  logic [DIGITS-1:0]     cs_n_q, cs_n_d;
  logic [7:0]            dx_q, dx_d;

  logic                  advance, frame_wrap, accept;
  logic [3:0]            cur_digit;
  logic                  cur_dp;

  function automatic logic [7:0] seg_encode(input logic [3:0] d, input logic dp);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    s[7] = ~dp;
    return s;
  endfunction

  // Handshake: a word transfers on a clk edge where din_valid && din_ready;
  // din_ready is low whenever the pending slot is full, so nothing is dropped.
  assign din_ready = ~full_q;
  assign accept    = din_valid && ~full_q;
  assign cs_n      = cs_n_q;
  assign dx        = dx_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    idx_d      = idx_q;
    advance    = 1'b0;
    frame_wrap = 1'b0;
    case (state_q)
      ST_DRIVE: if (cnt_q == SCAN_LAST) begin
        cnt_d = '0;
        if (HAS_BLANK) state_d = ST_BLANK;
        else           advance = 1'b1;
      end
      ST_BLANK: if (cnt_q == BLANK_LAST) begin
        cnt_d   = '0;
        state_d = ST_DRIVE;
        advance = 1'b1;
      end
      default: state_d = ST_DRIVE;
    endcase
    if (advance) begin
      if (idx_q == IDX_LAST) begin
        idx_d      = '0;
        frame_wrap = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // The shadow only updates as idx wraps to 0, so a frame never mixes two words.
  always_comb begin
    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    full_d    = full_q;
    if (frame_wrap && full_q) begin
      disp_d    = pend_q;
      disp_dp_d = pend_dp_q;
      full_d    = 1'b0;
    end
    if (accept) begin
      pend_d    = din;
      pend_dp_d = dp_in;
      full_d    = 1'b1;
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = disp_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
      end
    end
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;
  always_comb begin
    msd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (disp_q[4*i +: 4] != 4'h0) msd = IW'(i);
    end
  end
`endif

  always_comb begin
    cs_n_d = '1;
    dx_d   = 8'hFF;
    if (state_q == ST_DRIVE) begin
      for (int i = 0; i < DIGITS; i++) cs_n_d[i] = (idx_q != IW'(i));
      dx_d = seg_encode(cur_digit, cur_dp);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (idx_q > msd) dx_d = {~cur_dp, 7'h7F};
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_DRIVE;
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      full_q    <= 1'b0;
      cs_n_q    <= '1;
      dx_q      <= 8'hFF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      full_q    <= full_d;
      cs_n_q    <= cs_n_d;
      dx_q      <= dx_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: per-frame expected digit windows queued by the driver,
// consumed by a negedge monitor that also checks window lengths and frame period.
module tb_seg_scan_driver;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;
  localparam int FRAME     = DIGITS * (SCAN_DIV + BLANK_CYC);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [3:0]  cs_n;
  logic [7:0]  dx;
  logic        dbg_state;

  logic [11:0] exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          frame_cnt = 0;
  bit          mon_en = 1'b0;
  bit          mon_restart = 1'b0;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .dp_in     (dp_in),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .cs_n      (cs_n),
    .dx        (dx),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, expv, $time);
    end
  endtask

  function automatic logic [7:0] exp_dx(input logic [15:0] w, input logic [3:0] p, input int i);
    logic [3:0] d;
    logic [7:0] t;
    d = w[4*i +: 4];
    t = seg_tbl[d];
    t[7] = ~p[i];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int k = 0; k < DIGITS; k++) if (w[4*k +: 4] != 4'h0) msd = k;
      if (i > msd) t = p[i] ? 8'h7F : 8'hFF;
    end
`endif
    return t;
  endfunction

  task automatic push_frame(input logic [15:0] w, input logic [3:0] p);
    logic [3:0] sel;
    for (int i = 0; i < DIGITS; i++) begin
      sel = ~(4'b0001 << i);
      exp_q.push_back({sel, exp_dx(w, p, i)});
    end
  endtask

  // driver tasks
  task automatic send(input logic [15:0] w, input logic [3:0] p, output int waited);
    din = w;
    dp_in = p;
    din_valid = 1'b1;
    waited = 0;
    while (din_ready !== 1'b1 && waited < 4*FRAME) begin
      @(negedge clk);
      waited++;
    end
    check_eq("send_ready", din_ready, 1);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    check_eq("ready_drop", din_ready, 0);
  endtask

  task automatic wait_frames(input int n);
    int t;
    t = 0;
    while (frame_cnt < n && t < 10*FRAME) begin
      @(negedge clk);
      t++;
    end
    check_eq("wait_frame", frame_cnt >= n, 1);
  endtask

  task automatic wait_sel(input logic [3:0] sel);
    int t;
    t = 0;
    while (cs_n !== sel && t < 2*FRAME) begin
      @(negedge clk);
      t++;
    end
    check_eq("wait_sel", cs_n, sel);
  endtask

  // scoreboard monitor
  logic [3:0] prev_cs = '1;
  logic [7:0] prev_dx = 8'hFF;
  int  run = 0;
  int  cyc = 0;
  int  last_f0 = 0;
  bit  have_run = 1'b0;
  bit  f0_seen = 1'b0;
  logic [11:0] e;

  always @(negedge clk) begin
    if (mon_restart) begin
      prev_cs = '1; prev_dx = 8'hFF; run = 0; cyc = 0;
      have_run = 1'b0; f0_seen = 1'b0; mon_restart = 1'b0;
    end
    if (mon_en) begin
      cyc++;
      check_eq("onehot", $countones(~cs_n) <= 1, 1);
      if (cs_n == 4'hF) check_eq("blank_dx", dx, 8'hFF);
      if (cs_n != prev_cs) begin
        if (have_run) begin
          if (prev_cs == 4'hF) check_eq("blank_len", run, BLANK_CYC);
          else                 check_eq("drive_len", run, SCAN_DIV);
        end
        have_run = 1'b1;
        run = 1;
        if (cs_n != 4'hF) begin
          if (exp_q.size() == 0) begin
            check_eq("exp_underflow", {cs_n, dx}, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("digit", {cs_n, dx}, e);
          end
          if (cs_n == 4'hE) begin
            if (f0_seen) check_eq("frame_period", cyc - last_f0, FRAME);
            f0_seen = 1'b1;
            last_f0 = cyc;
            frame_cnt++;
          end
        end
      end else begin
        run++;
        if (cs_n != 4'hF) check_eq("dx_stable", dx, prev_dx);
      end
      prev_cs = cs_n;
      prev_dx = dx;
    end
  end

  initial begin
    int w;
    int base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_cs", cs_n, 4'hF);
    check_eq("rst_dx", dx, 8'hFF);
    check_eq("rst_ready", din_ready, 1);

    push_frame(16'h0000, 4'h0);
    rst = 1'b0;
    mon_restart = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    check_eq("first_cs", cs_n, 4'hE);
    check_eq("first_dx", dx, 8'hC0);

    // scan order
    push_frame(16'h4321, 4'h0);
    send(16'h4321, 4'h0, w);

    // backpressure: second word waits for the boundary
    wait_frames(2);
    push_frame(16'hABCD, 4'h0);
    send(16'hABCD, 4'h0, w);
    push_frame(16'h1111, 4'h0);
    send(16'h1111, 4'h0, w);
    check_eq("bp_wait", w > 0, 1);

    // mid-frame load during digit 2
    wait_frames(4);
    wait_sel(4'b1011);
    push_frame(16'hFFFF, 4'h0);
    send(16'hFFFF, 4'h0, w);

    // decimal point
    wait_frames(5);
    push_frame(16'h0000, 4'b0100);
    send(16'h0000, 4'b0100, w);

    // async reset while a digit is driven and a word is pending
    wait_frames(6);
    wait_sel(4'b1101);
    din = 16'h5555;
    send(16'h5555, 4'hF, w);
    @(negedge clk);
    mon_en = 1'b0;
    check_eq("pre_rst_sel", cs_n, 4'b1101);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_cs", cs_n, 4'hF);
    check_eq("async_dx", dx, 8'hFF);
    check_eq("async_ready", din_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    check_eq("rst_hold_cs", cs_n, 4'hF);
    @(negedge clk);
    push_frame(16'h0000, 4'h0);
    push_frame(16'h0000, 4'h0);
    base = frame_cnt;
    mon_restart = 1'b1;
    mon_en = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("restart_cs", cs_n, 4'hE);
    check_eq("restart_dx", dx, 8'hC0);
    wait_frames(base + 2);
    repeat (FRAME - 3) @(negedge clk);
    mon_en = 1'b0;
    check_eq("exp_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
